// File: rtl/qnigma_eth_pkg.sv
// Shared definitions for the Ethernet transmit path: line constants, the
// framer state type, the frame length type and the byte-wide CRC-32 step.
package qnigma_eth_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE    = 8'h55;
   localparam logic [7:0]  SFD_BYTE         = 8'hD5;
   localparam logic [31:0] CRC_MAGIC_NUMBER = 32'hDEBB20E3;
   localparam logic [31:0] CRC_POLY_REFL    = 32'hEDB88320;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_DROP,
      ST_IFG
   } tx_state_t;

   typedef logic [10:0] frame_len_t;

   // One byte of reflected CRC-32, least significant bit first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] dat);
      logic [31:0] c;
      c = crc ^ {24'h000000, dat};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/qnigma_crc32.sv
// Byte-wide Ethernet CRC-32 engine. Accumulates while val is high and
// returns to all-ones on any cycle with val low; ok flags the FCS residue.
module qnigma_crc32
   import qnigma_eth_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  dat,
   input  logic        val,
   output logic [31:0] crc,
   output logic        ok
);

   logic [31:0] crc_q;

   // Accumulate on valid bytes, re-seed to all-ones otherwise.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with <= so every flop samples pre-edge values.
      if (!rst) begin
         crc_q <= '1;
      end else if (val) begin
         crc_q <= crc32_byte(crc_q, dat);
      end else begin
         crc_q <= '1;
      end
   end

   assign crc = crc_q;
   assign ok  = (crc_q == CRC_MAGIC_NUMBER);

endmodule

// File: rtl/qnigma_eth_tx_fcs.sv
// Ethernet TX framer: preamble/SFD, payload pass-through, zero padding,
// inverted FCS and inter-frame gap, with underrun and oversize handling.
module qnigma_eth_tx_fcs
   import qnigma_eth_pkg::*;
#(
   parameter int unsigned PRE_LEN = 7,
   parameter int unsigned MIN_LEN = 60,
   parameter int unsigned MAX_LEN = 1514,
   parameter int unsigned IFG_LEN = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_dat,
   input  logic       in_val,
   input  logic       in_lst,
   output logic       in_rdy,
   output logic [7:0] tx_dat,
   output logic       tx_en,
   output logic       tx_er,
   output logic       busy,
   output logic       frame_done,
   output logic       underrun,
   output logic       oversize
);

   localparam logic [7:0] PRE_LAST  = 8'(PRE_LEN);
   localparam logic [7:0] IFG_LAST  = 8'(IFG_LEN - 1);
   localparam logic [7:0] FCS_LAST  = 8'd3;
   localparam frame_len_t MIN_LEN_C = frame_len_t'(MIN_LEN);
   localparam frame_len_t MAX_LEN_C = frame_len_t'(MAX_LEN);

   tx_state_t   state_q, state_d;
   frame_len_t  len_q, len_d;
   frame_len_t  len_inc;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] fcs_q, fcs_d;
   logic        drop_q, drop_d;
   logic [7:0]  tx_dat_q, tx_dat_d;
   logic        tx_en_q, tx_en_d;
   logic        tx_er_q, tx_er_d;
   logic        done_q, done_d;
   logic        urun_q, urun_d;
   logic        ovs_q, ovs_d;

   logic        crc_val;
   logic [7:0]  crc_dat;
   logic [31:0] crc_reg;
   logic        crc_ok_unused;

   assign in_rdy  = (state_q == ST_DATA) || (state_q == ST_DROP);
   assign busy    = (state_q != ST_IDLE);
   assign len_inc = len_q + 11'd1;

   qnigma_crc32 u_crc (
      .clk (clk),
      .rst (rst),
      .dat (crc_dat),
      .val (crc_val),
      .crc (crc_reg),
      .ok  (crc_ok_unused)
   );

   // Next-state, next-output and CRC feed for the framing sequence.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no latches are inferred.
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      fcs_d    = fcs_q;
      drop_d   = drop_q;
      tx_dat_d = 8'h00;
      tx_en_d  = 1'b0;
      tx_er_d  = 1'b0;
      done_d   = 1'b0;
      urun_d   = 1'b0;
      ovs_d    = 1'b0;
      crc_val  = 1'b0;
      crc_dat  = 8'h00;

      unique case (state_q)
         ST_IDLE: begin
            if (in_val) begin
               state_d  = ST_PRE;
               tx_en_d  = 1'b1;
               tx_dat_d = PREAMBLE_BYTE;
               cnt_d    = 8'd1;
               len_d    = '0;
               drop_d   = 1'b0;
            end
         end
         ST_PRE: begin
            tx_en_d = 1'b1;
            if (cnt_q == PRE_LAST) begin
               tx_dat_d = SFD_BYTE;
               state_d  = ST_DATA;
            end else begin
               tx_dat_d = PREAMBLE_BYTE;
               cnt_d    = cnt_q + 8'd1;
            end
         end
         ST_DATA: begin
            tx_en_d = 1'b1;
            cnt_d   = '0;
            if (!in_val) begin
               // Upstream starved mid-frame: mark the line and discard the rest.
               tx_er_d = 1'b1;
               urun_d  = 1'b1;
               state_d = ST_DROP;
            end else begin
               tx_dat_d = in_dat;
               crc_val  = 1'b1;
               crc_dat  = in_dat;
               len_d    = len_inc;
               if (in_lst) begin
                  state_d = (len_inc < MIN_LEN_C) ? ST_PAD : ST_FCS;
               end else if (len_inc == MAX_LEN_C) begin
                  ovs_d   = 1'b1;
                  drop_d  = 1'b1;
                  state_d = ST_FCS;
               end
            end
         end
         ST_PAD: begin
            tx_en_d = 1'b1;
            crc_val = 1'b1;
            len_d   = len_inc;
            cnt_d   = '0;
            if (len_inc == MIN_LEN_C) begin
               state_d = ST_FCS;
            end
         end
         ST_FCS: begin
            tx_en_d = 1'b1;
            cnt_d   = cnt_q + 8'd1;
            // The engine re-seeds after this cycle, so keep the rest of its value here.
            if (cnt_q == 8'd0) begin
               tx_dat_d = ~crc_reg[7:0];
               fcs_d    = {8'h00, crc_reg[31:8]};
            end else begin
               tx_dat_d = ~fcs_q[7:0];
               fcs_d    = {8'h00, fcs_q[31:8]};
            end
            if (cnt_q == FCS_LAST) begin
               done_d  = 1'b1;
               cnt_d   = '0;
               drop_d  = 1'b0;
               state_d = drop_q ? ST_DROP : ST_IFG;
            end
         end
         ST_DROP: begin
            cnt_d = '0;
            if (in_val && in_lst) begin
               state_d = ST_IFG;
            end
         end
         ST_IFG: begin
            if (cnt_q == IFG_LAST) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered line outputs; reset aborts any frame in progress.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         fcs_q    <= '0;
         drop_q   <= 1'b0;
         tx_dat_q <= 8'h00;
         tx_en_q  <= 1'b0;
         tx_er_q  <= 1'b0;
         done_q   <= 1'b0;
         urun_q   <= 1'b0;
         ovs_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         fcs_q    <= fcs_d;
         drop_q   <= drop_d;
         tx_dat_q <= tx_dat_d;
         tx_en_q  <= tx_en_d;
         tx_er_q  <= tx_er_d;
         done_q   <= done_d;
         urun_q   <= urun_d;
         ovs_q    <= ovs_d;
      end
   end

   assign tx_dat     = tx_dat_q;
   assign tx_en      = tx_en_q;
   assign tx_er      = tx_er_q;
   assign frame_done = done_q;
   assign underrun   = urun_q;
   assign oversize   = ovs_q;

endmodule

// File: tb/tb_qnigma_eth_tx_fcs.sv
// Scoreboard bench for qnigma_eth_tx_fcs: the driver pushes the expected
// line bytes of each frame, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_qnigma_eth_tx_fcs;

   localparam int PRE_LEN = 7;
   localparam int MIN_LEN = 60;
   localparam int MAX_LEN = 1514;
   localparam int IFG_LEN = 12;

   typedef logic [7:0] bytes_t[$];
   typedef struct packed {
      logic [7:0] dat;
      logic       er;
      logic       done;
      logic       ur;
      logic       ov;
   } line_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_dat = 8'h00;
   logic       in_val = 1'b0;
   logic       in_lst = 1'b0;
   logic       in_rdy, tx_en, tx_er, busy, frame_done, underrun, oversize;
   logic [7:0] tx_dat;

   line_t  exp_q[$];
   bytes_t cap_q;
   int     checks = 0;
   int     failures = 0;
   int     idle_run = 0;
   int     last_gap = 0;
   int     line_idx = 0;
   bit     skip_gap = 1'b1;
   bit     prev_en = 1'b0;
   bit     abort = 1'b0;

   always #5 clk = ~clk;

   qnigma_eth_tx_fcs #(
      .PRE_LEN (PRE_LEN),
      .MIN_LEN (MIN_LEN),
      .MAX_LEN (MAX_LEN),
      .IFG_LEN (IFG_LEN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_dat     (in_dat),
      .in_val     (in_val),
      .in_lst     (in_lst),
      .in_rdy     (in_rdy),
      .tx_dat     (tx_dat),
      .tx_en      (tx_en),
      .tx_er      (tx_er),
      .busy       (busy),
      .frame_done (frame_done),
      .underrun   (underrun),
      .oversize   (oversize)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Textbook serial CRC-32: bits enter LSB first into an MSB-first divider
   // with the normal polynomial; the result is returned bit-reversed so it
   // lines up with the on-wire (reflected) byte order.
   function automatic logic [31:0] crc_refl(input bytes_t b);
      logic [31:0] r, o;
      logic        fb;
      r = 32'hFFFFFFFF;
      foreach (b[i]) begin
         for (int k = 0; k < 8; k++) begin
            fb = r[31] ^ b[i][k];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ 32'h04C11DB7;
         end
      end
      for (int i = 0; i < 32; i++) o[i] = r[31-i];
      return o;
   endfunction

   function automatic line_t mk(input logic [7:0] d, input logic er, input logic done,
                                input logic ur, input logic ov);
      line_t e;
      e.dat = d; e.er = er; e.done = done; e.ur = ur; e.ov = ov;
      return e;
   endfunction

   // Reference model: the full line image of one frame request.
   task automatic push_frame(input bytes_t pl, input int ur_at, input int rst_at);
      bytes_t      body;
      logic [31:0] fcs;
      int          n, sent;
      n = pl.size();
      repeat (PRE_LEN) exp_q.push_back(mk(8'h55, 0, 0, 0, 0));
      exp_q.push_back(mk(8'hD5, 0, 0, 0, 0));
      if (rst_at >= 0) begin
         for (int i = 0; i < rst_at; i++) exp_q.push_back(mk(pl[i], 0, 0, 0, 0));
         return;
      end
      if (ur_at >= 0) begin
         for (int i = 0; i < ur_at; i++) exp_q.push_back(mk(pl[i], 0, 0, 0, 0));
         exp_q.push_back(mk(8'h00, 1, 0, 1, 0));
         return;
      end
      sent = (n > MAX_LEN) ? MAX_LEN : n;
      for (int i = 0; i < sent; i++) body.push_back(pl[i]);
      while (body.size() < MIN_LEN) body.push_back(8'h00);
      foreach (body[i]) exp_q.push_back(mk(body[i], 0, 0, 0, (n > MAX_LEN) && (i == sent - 1)));
      fcs = ~crc_refl(body);
      for (int k = 0; k < 4; k++) exp_q.push_back(mk(fcs[8*k +: 8], 0, k == 3, 0, 0));
   endtask

   // Drive one frame with handshake; optional underrun gap or mid-frame reset.
   task automatic send_frame(input bytes_t pl, input int ur_at, input int rst_at, input bit hold);
      bit acc;
      int w;
      if (abort) return;
      push_frame(pl, ur_at, rst_at);
      for (int i = 0; i < pl.size(); i++) begin
         if (i == rst_at) begin
            in_val = 1'b0; in_lst = 1'b0; rst = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1; skip_gap = 1'b1;
            return;
         end
         if (i == ur_at) begin
            in_val = 1'b0; in_lst = 1'b0;
            @(posedge clk); #1;
         end
         in_val = 1'b1; in_dat = pl[i]; in_lst = (i == pl.size() - 1);
         w = 0;
         do begin
            @(negedge clk); acc = in_rdy;
            @(posedge clk); #1;
            w++;
         end while (!acc && w < 100);
         if (!acc) begin
            failures++;
            $display("FAIL accept_timeout byte=%0d waited=%0d cycles required in_rdy=1", i, w);
            abort = 1'b1;
            in_val = 1'b0;
            return;
         end
      end
      if (!hold) begin
         in_val = 1'b0; in_lst = 1'b0;
      end
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(negedge clk); n++;
      end
      check({tag, "_drain_left"}, exp_q.size(), 0);
      repeat (IFG_LEN + 2) @(negedge clk);
      check({tag, "_busy_after"}, {31'd0, busy}, 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_tx_dat"}, {24'd0, tx_dat}, 0);
      check({tag, "_tx_en"}, {31'd0, tx_en}, 0);
      check({tag, "_tx_er"}, {31'd0, tx_er}, 0);
      check({tag, "_in_rdy"}, {31'd0, in_rdy}, 0);
      check({tag, "_busy"}, {31'd0, busy}, 0);
      check({tag, "_pulses"}, {29'd0, frame_done, underrun, oversize}, 0);
   endtask

   function automatic bytes_t rand_bytes(input int n);
      bytes_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255)));
      return q;
   endfunction

   function automatic bytes_t tail(input bytes_t q, input int from, input int to);
      bytes_t r;
      for (int i = from; i < to && i < q.size(); i++) r.push_back(q[i]);
      return r;
   endfunction

   // Monitor: compare every active line cycle against the scoreboard.
   always @(negedge clk) begin
      line_t act;
      if (tx_en) begin
         if (!prev_en) begin
            if (!skip_gap) check("ifg_min", {31'd0, idle_run >= IFG_LEN}, 1);
            last_gap = idle_run;
            skip_gap = 1'b0;
         end
         idle_run = 0;
         cap_q.push_back(tx_dat);
      end else begin
         idle_run++;
      end
      prev_en = tx_en;
      if (tx_en || tx_er || frame_done || underrun || oversize) begin
         act = mk(tx_dat, tx_er, frame_done, underrun, oversize);
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL line_unexpected idx=%0d actual=0x%0h expected=none", line_idx, act);
         end else begin
            check($sformatf("line[%0d]", line_idx), {20'd0, act}, {20'd0, exp_q.pop_front()});
         end
         line_idx++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bytes_t pl, pl2, post;
      int     n, ur;

      repeat (2) @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset");

      // 1-byte frame: preamble, SFD, data, 59 pad, FCS; residue over 64 bytes.
      cap_q.delete();
      pl = {8'hAB};
      send_frame(pl, -1, -1, 1'b0);
      drain("t1");
      check("t1_tx_en_cycles", cap_q.size(), 72);
      post = tail(cap_q, 8, 72);
      check("t1_residue", crc_refl(post), 32'hDEBB20E3);

      // 100-byte incrementing frame, no padding.
      pl.delete();
      for (int i = 0; i < 100; i++) pl.push_back(8'(i));
      send_frame(pl, -1, -1, 1'b0);
      drain("t2");

      // Underrun at byte 20 of 40.
      send_frame(rand_bytes(40), 20, -1, 1'b0);
      drain("t3");

      // Oversize 1600-byte request.
      send_frame(rand_bytes(1600), -1, -1, 1'b0);
      drain("t4");

      // Exactly MAX_LEN with in_lst: ordinary last byte.
      send_frame(rand_bytes(MAX_LEN), -1, -1, 1'b0);
      drain("t4b");

      // Back-to-back 64-byte frames with in_val held through the gap.
      cap_q.delete();
      pl  = rand_bytes(64);
      pl2 = rand_bytes(64);
      send_frame(pl, -1, -1, 1'b1);
      send_frame(pl2, -1, -1, 1'b0);
      drain("t5");
      check("t5_gap", last_gap, IFG_LEN);
      post = tail(cap_q, 76 + 8, 152);
      check("t5_residue", crc_refl(post), 32'hDEBB20E3);

      // Reset during DATA byte 10, then a fresh frame.
      send_frame(rand_bytes(30), -1, 10, 1'b0);
      @(negedge clk);
      check_idle_outputs("t6_reset");
      check("t6_sb_empty", exp_q.size(), 0);
      send_frame(rand_bytes(50), -1, -1, 1'b0);
      drain("t6");

      // Randomised frames, some with an underrun.
      for (int f = 0; f < 10 && !abort; f++) begin
         n  = $urandom_range(130, 1);
         ur = (n > 1 && $urandom_range(3) == 0) ? int'($urandom_range(n - 1, 1)) : -1;
         repeat ($urandom_range(4)) @(posedge clk);
         #1;
         send_frame(rand_bytes(n), ur, -1, 1'b0);
         drain($sformatf("rnd%0d", f));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/qnigma_eth_tx_fcs.md
Name: qnigma_eth_tx_fcs

Overview:
Ethernet TX framer sitting between the MAC transmit byte stream and the GMII-style byte interface. It sequences one qnigma_crc32 instance and adds the framing around each payload:
- prepends preamble and SFD;
- pads short payloads with zeros;
- appends the inverted FCS;
- enforces the inter-frame gap.

It also detects upstream underrun and oversize frames. The output is a continuous byte stream with no backpressure.

Parameters:
PRE_LEN, 7, number of 0x55 preamble bytes before SFD
MIN_LEN, 60, minimum payload bytes before FCS (zero padding up to this)
MAX_LEN, 1514, maximum transmitted payload bytes before FCS
IFG_LEN, 12, idle cycles after a frame (tx_en low)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low (rst=0 resets on clk rising edge)
in_dat  in  8  payload byte
in_val  in  1  payload byte valid / frame request
in_lst  in  1  current byte is last of frame
in_rdy  out  1  byte accepted when in_val&in_rdy
tx_dat  out  8  line byte (registered)
tx_en  out  1  line byte valid (registered)
tx_er  out  1  line error marker (registered)
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse on the last FCS byte
underrun  out  1  one-cycle pulse on underrun detection
oversize  out  1  one-cycle pulse when MAX_LEN reached without in_lst

Behaviour:
- Reset values: tx_dat=0, tx_en=0, tx_er=0, in_rdy=0, busy=0, all pulses 0, state IDLE, counters 0. Reset mid-frame aborts immediately, with no FCS and no IFG.
- States: IDLE, PRE, DATA, PAD, FCS, DROP, IFG.
- in_rdy is combinational: 1 iff state is DATA or DROP. It is never high in IDLE, PRE, PAD, FCS or IFG.
- IDLE: in_val=1 at cycle 0 moves to PRE. The first byte is held upstream.
- PRE:
  - tx_en=1 from cycle 1.
  - tx_dat=0x55 for cycles 1..PRE_LEN, then 0xD5 at cycle PRE_LEN+1.
  - State becomes DATA in the same cycle the SFD is driven (cycle 8 for default PRE_LEN=7).
- Line latency: a byte accepted in cycle t appears on tx_dat at t+1.
- DATA:
  - Each accepted byte increments the 11-bit length counter len.
  - in_lst accepted with len+1 < MIN_LEN goes to PAD; otherwise it goes to FCS.
  - in_val=0 in DATA is an underrun:
    - that cycle drives tx_dat=0x00, tx_en=1, tx_er=1 at the next edge;
    - underrun pulses;
    - state goes to DROP.
  - len reaching MAX_LEN without in_lst:
    - oversize pulses;
    - state goes to FCS, so the frame is closed with a valid FCS over the MAX_LEN bytes;
    - a drop flag is set so the remaining input is consumed in DROP after FCS.
- PAD: emits 0x00 until len==MIN_LEN, then goes to FCS.
- CRC feed:
  - crc dat = the byte going to the line (accepted byte or 0x00 pad).
  - crc val = 1 only in DATA-accept and PAD cycles.
  - val=0 at all other times, so the engine re-initialises to all-ones between frames.
  - Preamble and SFD are excluded from the CRC.
- FCS:
  - On entry, latch the engine's crc register into a 32-bit shift register. Needed because val=0 re-initialises the engine on the next edge.
  - Emit ~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24] in that order, immediately after the last data/pad byte with no gap.
  - frame_done pulses with the 4th FCS byte.
  - Next state is DROP if the drop flag is set, else IFG.
- DROP:
  - tx_en=0; in_rdy=1; input bytes are consumed without transmission.
  - Leaves on accepted in_lst to IFG.
  - An underrun that coincides with in_lst accepted on the same cycle cannot occur (in_val=0). An underrun on what would have been the last byte still enters DROP.
- IFG: tx_en=0 for exactly IFG_LEN cycles, then IDLE. in_val held high during IFG starts PRE on the cycle IDLE is entered, with no extra idle cycle.
- Simultaneous events:
  - oversize and in_lst on the same byte is treated as a normal last byte: no oversize pulse, no DROP.
  - Underrun takes priority in DATA.

Decomposition:
- Package qnigma_eth_pkg holds:
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_MAGIC_NUMBER=32'hDEBB20E3;
  - the state enum type;
  - the length counter typedef (11 bits).
- One sub-module: the existing qnigma_crc32, instantiated once. Its ok output is unused here.

Test Plan:
1. 1-byte frame 0xAB with in_lst → tx_en high for 72 cycles: 7×0x55, 0xD5, 0xAB, 59×0x00, 4 FCS bytes. frame_done on cycle 72. Then 12 cycles tx_en=0. Feeding the 64 post-SFD bytes into a checker qnigma_crc32 gives ok=1 (0xDEBB20E3).
2. 100-byte frame, bytes 0x00..0x63 → no pad; 100 data bytes then 4 FCS. FCS equals the software reflected CRC-32 (init 0xFFFFFFFF, final inversion) of the payload, LSB byte first.
3. Underrun: in_val dropped at byte 20 of a 40-byte frame → tx_er=1 with tx_dat=0x00 for one cycle, no FCS, underrun pulse. Remaining 20 bytes are consumed with tx_en=0, then 12 IFG cycles.
4. 1600-byte frame → 1514 bytes plus a valid FCS on the line, oversize pulse. The remaining 86 bytes are consumed with in_rdy=1 and tx_en=0. Then IFG.
5. Back-to-back 64-byte frames, second in_val held through IFG → exactly 12 tx_en=0 cycles between frames. The second FCS is correct, confirming the CRC re-initialised.
6. rst=0 for one cycle during DATA byte 10 → next cycle all outputs 0, in_rdy=0, state IDLE. A new frame afterwards is transmitted with a correct FCS.
